memory_access: RTL and testbench

Memory stage of the five-stage DLX pipeline, between the execute stage and `write_back`. Performs loads and stores against a variable-latency data memory over a req/ack handshake and stalls the upstream stages while an access is outstanding. Handles big-endian byte, halfword and word alignment, and sign or zero extension of load data. Registers the MEM/WB pipeline fields that `write_back` consumes.

---
 rtl/memory_access_pkg.sv | 39 +++
 rtl/mem_align.sv | 56 +++++
 rtl/memory_access.sv | 162 ++++++++++++++++
 tb/tb_memory_access.sv | 284 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/memory_access_pkg.sv
// Shared encodings for the DLX memory stage: access sizes, FSM states and the MEM/WB bundle.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package memory_access_pkg;

    localparam logic [1:0] SIZE_BYTE = 2'b00;
    localparam logic [1:0] SIZE_HALF = 2'b01;
    localparam logic [1:0] SIZE_WORD = 2'b10;

    localparam int MEMWB_DATA_W     = 32;
    localparam int MEMWB_REG_ADDR_W = 5;

    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_ACCESS = 1'b1
    } state_t;

    // Field bundle consumed by write_back.
    typedef struct packed {
        logic [MEMWB_DATA_W-1:0]     mem_data;
        logic [MEMWB_DATA_W-1:0]     alu_data;
        logic                        reg_wr_en;
        logic [MEMWB_REG_ADDR_W-1:0] reg_wr_addr;
        logic                        wb_sel;
    } memwb_t;

    // Instruction fields held for the duration of an outstanding access.
    typedef struct packed {
        logic [1:0]                  addr_lo;
        logic [1:0]                  size;
        logic                        sign_ext;
        logic                        is_store;
        logic [MEMWB_DATA_W-1:0]     alu_data;
        logic                        reg_wr_en;
        logic [MEMWB_REG_ADDR_W-1:0] reg_wr_addr;
        logic                        wb_sel;
    } hold_t;

endpackage

// File: rtl/mem_align.sv
// Big-endian lane logic: byte enables, store replication, load select/extend, misalign flag.
// Latency: purely combinational.
// Backpressure: none.
module mem_align
    import memory_access_pkg::*;
(
    input  logic [1:0]  addr_lo,
    input  logic [1:0]  size,
    input  logic        sign_ext,
    input  logic [31:0] store_data,
    input  logic [31:0] rdata,
    output logic [3:0]  be,
    output logic [31:0] wdata,
    output logic [31:0] load_data,
    output logic        misalign
);

    logic [7:0]  byte_lane;
    logic [15:0] half_lane;

    always_comb begin
        byte_lane = rdata[31:24];
        case (addr_lo)
            2'd0:    byte_lane = rdata[31:24];
            2'd1:    byte_lane = rdata[23:16];
            2'd2:    byte_lane = rdata[15:8];
            default: byte_lane = rdata[7:0];
        endcase
        half_lane = addr_lo[1] ? rdata[15:0] : rdata[31:16];
    end

    // Offending low bits are ignored here; the caller decides whether to trap.
    always_comb begin
        be        = 4'b1111;
        wdata     = store_data;
        load_data = rdata;
        misalign  = 1'b0;
        case (size)
            SIZE_BYTE: begin
                be        = 4'b1000 >> addr_lo;
                wdata     = {4{store_data[7:0]}};
                load_data = {{24{sign_ext & byte_lane[7]}}, byte_lane};
            end
            SIZE_HALF: begin
                be        = 4'b1100 >> {addr_lo[1], 1'b0};
                wdata     = {2{store_data[15:0]}};
                load_data = {{16{sign_ext & half_lane[15]}}, half_lane};
                misalign  = addr_lo[0];
            end
            default: begin
                misalign  = |addr_lo;
            end
        endcase
    end

endmodule

// File: rtl/memory_access.sv
// DLX memory stage: issues loads/stores on a req/ack data-memory port and registers MEM/WB (MEM_MISALIGN_TRAP_EN adds a misalign trap).
// Latency: 1 cycle for non-memory ops, 1 + N cycles for memory ops (N = request-to-ack cycles, N >= 1).
// Backpressure: stall_out holds upstream while a memory op is being issued or awaiting ack.
module memory_access
    import memory_access_pkg::*;
#(
    parameter int DATA_WIDTH     = 32,
    parameter int ADDR_WIDTH     = 32,
    parameter int REG_ADDR_WIDTH = 5
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      ex_valid_in,
    input  logic [DATA_WIDTH-1:0]     alu_data_in,
    input  logic [DATA_WIDTH-1:0]     store_data_in,
    input  logic                      mem_rd_en_in,
    input  logic                      mem_wr_en_in,
    input  logic [1:0]                mem_size_in,
    input  logic                      mem_sign_ext_in,
    input  logic                      reg_wr_en_in,
    input  logic [REG_ADDR_WIDTH-1:0] reg_wr_addr_in,
    input  logic                      write_back_mux_sel_in,
    output logic                      stall_out,
    output logic                      dmem_req_out,
    output logic                      dmem_we_out,
    output logic [ADDR_WIDTH-1:0]     dmem_addr_out,
    output logic [DATA_WIDTH-1:0]     dmem_wdata_out,
    output logic [DATA_WIDTH/8-1:0]   dmem_be_out,
    input  logic [DATA_WIDTH-1:0]     dmem_rdata_in,
    input  logic                      dmem_ack_in,
`ifdef MEM_MISALIGN_TRAP_EN
    output logic                      misalign_exc_out,
`endif
    output logic [DATA_WIDTH-1:0]     mem_data_out,
    output logic [DATA_WIDTH-1:0]     alu_data_out,
    output logic                      reg_wr_en_out,
    output logic [REG_ADDR_WIDTH-1:0] reg_wr_addr_out,
    output logic                      write_back_mux_sel_out
);

    state_t state;
    hold_t  hold;
    memwb_t memwb;

    logic        mem_op;
    logic        start;
    logic        trap;
    logic        misalign;
    logic [1:0]  al_addr_lo;
    logic [1:0]  al_size;
    logic        al_sign;
    logic [3:0]  al_be;
    logic [31:0] al_wdata;
    logic [31:0] al_load;

    assign mem_op = ex_valid_in & (mem_rd_en_in | mem_wr_en_in);

    // Live fields set up the request; held fields shape the returning load data.
    assign al_addr_lo = (state == ST_ACCESS) ? hold.addr_lo  : alu_data_in[1:0];
    assign al_size    = (state == ST_ACCESS) ? hold.size     : mem_size_in;
    assign al_sign    = (state == ST_ACCESS) ? hold.sign_ext : mem_sign_ext_in;

    mem_align u_align (
        .addr_lo    (al_addr_lo),
        .size       (al_size),
        .sign_ext   (al_sign),
        .store_data (store_data_in),
        .rdata      (dmem_rdata_in),
        .be         (al_be),
        .wdata      (al_wdata),
        .load_data  (al_load),
        .misalign   (misalign)
    );

`ifdef MEM_MISALIGN_TRAP_EN
    assign trap = (state == ST_IDLE) & mem_op & misalign;
`else
    logic misalign_unused;
    assign misalign_unused = misalign;
    assign trap            = 1'b0;
`endif

    assign start     = (state == ST_IDLE) & mem_op & ~trap;
    assign stall_out = (state == ST_IDLE) ? start : ~dmem_ack_in;

    always_ff @(posedge clk) begin
        if (rst) begin
            state          <= ST_IDLE;
            dmem_req_out   <= 1'b0;
            dmem_we_out    <= 1'b0;
            dmem_addr_out  <= '0;
            dmem_wdata_out <= '0;
            dmem_be_out    <= '0;
            hold           <= '0;
            memwb          <= '0;
`ifdef MEM_MISALIGN_TRAP_EN
            misalign_exc_out <= 1'b0;
`endif
        end else begin
`ifdef MEM_MISALIGN_TRAP_EN
            misalign_exc_out <= 1'b0;
`endif
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        dmem_req_out     <= 1'b1;
                        dmem_we_out      <= mem_wr_en_in;
                        dmem_addr_out    <= {alu_data_in[ADDR_WIDTH-1:2], 2'b00};
                        dmem_wdata_out   <= al_wdata;
                        dmem_be_out      <= al_be;
                        hold.addr_lo     <= alu_data_in[1:0];
                        hold.size        <= mem_size_in;
                        hold.sign_ext    <= mem_sign_ext_in;
                        hold.is_store    <= mem_wr_en_in;
                        hold.alu_data    <= alu_data_in;
                        hold.reg_wr_en   <= reg_wr_en_in;
                        hold.reg_wr_addr <= reg_wr_addr_in;
                        hold.wb_sel      <= write_back_mux_sel_in;
                        memwb.reg_wr_en  <= 1'b0;
                        state            <= ST_ACCESS;
                    end
`ifdef MEM_MISALIGN_TRAP_EN
                    else if (trap) begin
                        misalign_exc_out <= 1'b1;
                        memwb.reg_wr_en  <= 1'b0;
                    end
`endif
                    else begin
                        memwb.alu_data    <= alu_data_in;
                        memwb.reg_wr_en   <= reg_wr_en_in & ex_valid_in;
                        memwb.reg_wr_addr <= reg_wr_addr_in;
                        memwb.wb_sel      <= write_back_mux_sel_in;
                    end
                end
                ST_ACCESS: begin
                    if (dmem_ack_in) begin
                        if (!hold.is_store) begin
                            memwb.mem_data <= al_load;
                        end
                        // A store never writes the register file, even if both enables were set.
                        memwb.alu_data    <= hold.alu_data;
                        memwb.reg_wr_en   <= hold.reg_wr_en & ~hold.is_store;
                        memwb.reg_wr_addr <= hold.reg_wr_addr;
                        memwb.wb_sel      <= hold.wb_sel;
                        dmem_req_out      <= 1'b0;
                        state             <= ST_IDLE;
                    end else begin
                        memwb.reg_wr_en   <= 1'b0;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign mem_data_out           = memwb.mem_data;
    assign alu_data_out           = memwb.alu_data;
    assign reg_wr_en_out          = memwb.reg_wr_en;
    assign reg_wr_addr_out        = memwb.reg_wr_addr;
    assign write_back_mux_sel_out = memwb.wb_sel;

endmodule

// File: tb/tb_memory_access.sv
// Directed bench for memory_access: reset, ALU pass-through, loads, stores, reset mid-access, misalign handling.
`timescale 1ns/1ps
module tb_memory_access;

    logic        clk = 1'b0;
    logic        rst;
    logic        ex_valid_in;
    logic [31:0] alu_data_in;
    logic [31:0] store_data_in;
    logic        mem_rd_en_in;
    logic        mem_wr_en_in;
    logic [1:0]  mem_size_in;
    logic        mem_sign_ext_in;
    logic        reg_wr_en_in;
    logic [4:0]  reg_wr_addr_in;
    logic        write_back_mux_sel_in;
    logic        stall_out;
    logic        dmem_req_out;
    logic        dmem_we_out;
    logic [31:0] dmem_addr_out;
    logic [31:0] dmem_wdata_out;
    logic [3:0]  dmem_be_out;
    logic [31:0] dmem_rdata_in;
    logic        dmem_ack_in;
`ifdef MEM_MISALIGN_TRAP_EN
    logic        misalign_exc_out;
`endif
    logic [31:0] mem_data_out;
    logic [31:0] alu_data_out;
    logic        reg_wr_en_out;
    logic [4:0]  reg_wr_addr_out;
    logic        write_back_mux_sel_out;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    memory_access dut (
        .clk                    (clk),
        .rst                    (rst),
        .ex_valid_in            (ex_valid_in),
        .alu_data_in            (alu_data_in),
        .store_data_in          (store_data_in),
        .mem_rd_en_in           (mem_rd_en_in),
        .mem_wr_en_in           (mem_wr_en_in),
        .mem_size_in            (mem_size_in),
        .mem_sign_ext_in        (mem_sign_ext_in),
        .reg_wr_en_in           (reg_wr_en_in),
        .reg_wr_addr_in         (reg_wr_addr_in),
        .write_back_mux_sel_in  (write_back_mux_sel_in),
        .stall_out              (stall_out),
        .dmem_req_out           (dmem_req_out),
        .dmem_we_out            (dmem_we_out),
        .dmem_addr_out          (dmem_addr_out),
        .dmem_wdata_out         (dmem_wdata_out),
        .dmem_be_out            (dmem_be_out),
        .dmem_rdata_in          (dmem_rdata_in),
        .dmem_ack_in            (dmem_ack_in),
`ifdef MEM_MISALIGN_TRAP_EN
        .misalign_exc_out       (misalign_exc_out),
`endif
        .mem_data_out           (mem_data_out),
        .alu_data_out           (alu_data_out),
        .reg_wr_en_out          (reg_wr_en_out),
        .reg_wr_addr_out        (reg_wr_addr_out),
        .write_back_mux_sel_out (write_back_mux_sel_out)
    );

    task automatic idle_inputs();
        ex_valid_in = 1'b0; mem_rd_en_in = 1'b0; mem_wr_en_in = 1'b0;
        reg_wr_en_in = 1'b0; dmem_ack_in = 1'b0;
    endtask

    // Runs one memory op with a fixed ack delay; entered and left just after a rising edge.
    task automatic do_mem(
        input  logic [31:0] addr, input logic [1:0] size, input logic sgn,
        input  logic rd, input logic wr, input logic [31:0] sdata,
        input  logic rwe, input logic [4:0] rwa, input logic wbs,
        input  int wait_cyc, input logic [31:0] rdata,
        output int stalls, output int pulses,
        output logic req0, output logic we0, output logic [31:0] addr0,
        output logic [3:0] be0, output logic [31:0] wdata0, output logic stable,
        output logic [31:0] mdata, output logic [31:0] alu_o,
        output logic [4:0] rwa_o, output logic wbs_o, output logic req_after);
        ex_valid_in = 1'b1; alu_data_in = addr; mem_size_in = size; mem_sign_ext_in = sgn;
        mem_rd_en_in = rd; mem_wr_en_in = wr; store_data_in = sdata;
        reg_wr_en_in = rwe; reg_wr_addr_in = rwa; write_back_mux_sel_in = wbs;
        dmem_ack_in = 1'b0;
        stalls = 0; pulses = 0; stable = 1'b1;
        @(negedge clk); if (stall_out) stalls++;
        @(posedge clk); #1;
        if (reg_wr_en_out) pulses++;
        req0 = dmem_req_out; we0 = dmem_we_out; addr0 = dmem_addr_out;
        be0 = dmem_be_out; wdata0 = dmem_wdata_out;
        for (int i = 0; i < wait_cyc; i++) begin
            @(negedge clk); if (stall_out) stalls++;
            @(posedge clk); #1;
            if (reg_wr_en_out) pulses++;
            if (dmem_req_out !== 1'b1 || dmem_addr_out !== addr0 || dmem_be_out !== be0 ||
                dmem_we_out !== we0 || dmem_wdata_out !== wdata0) stable = 1'b0;
        end
        dmem_ack_in = 1'b1; dmem_rdata_in = rdata;
        @(negedge clk); if (stall_out) stalls++;
        @(posedge clk); #1;
        idle_inputs();
        dmem_rdata_in = 32'h0BAD_F00D;
        if (reg_wr_en_out) pulses++;
        mdata = mem_data_out; alu_o = alu_data_out; rwa_o = reg_wr_addr_out;
        wbs_o = write_back_mux_sel_out; req_after = dmem_req_out;
        @(posedge clk); #1;
        if (reg_wr_en_out) pulses++;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        idle_inputs();
        alu_data_in = 32'h0; store_data_in = 32'h0; mem_size_in = 2'b00; mem_sign_ext_in = 1'b0;
        reg_wr_addr_in = 5'd0; write_back_mux_sel_in = 1'b0; dmem_rdata_in = 32'h0;
        repeat (3) @(posedge clk);
        #1;
        n_tests++; if (dmem_req_out !== 1'b0) begin n_fail++; $display("FAIL rst_req: got %b want 0", dmem_req_out); end
        n_tests++; if ({dmem_we_out, dmem_be_out} !== 5'b0) begin n_fail++; $display("FAIL rst_we_be: got %b want 00000", {dmem_we_out, dmem_be_out}); end
        n_tests++; if ({dmem_addr_out, dmem_wdata_out} !== 64'h0) begin n_fail++; $display("FAIL rst_addr_wdata: got %h want 0", {dmem_addr_out, dmem_wdata_out}); end
        n_tests++; if ({mem_data_out, alu_data_out, reg_wr_en_out, reg_wr_addr_out, write_back_mux_sel_out} !== 71'h0) begin
            n_fail++; $display("FAIL rst_memwb: got %h/%h/%b/%0d/%b want all 0", mem_data_out, alu_data_out, reg_wr_en_out, reg_wr_addr_out, write_back_mux_sel_out); end
        n_tests++; if (stall_out !== 1'b0) begin n_fail++; $display("FAIL rst_stall: got %b want 0", stall_out); end
`ifdef MEM_MISALIGN_TRAP_EN
        n_tests++; if (misalign_exc_out !== 1'b0) begin n_fail++; $display("FAIL rst_misalign: got %b want 0", misalign_exc_out); end
`endif
        rst = 1'b0;
    endtask

    task automatic test_alu_op();
        ex_valid_in = 1'b1; alu_data_in = 32'h1234; reg_wr_en_in = 1'b1;
        reg_wr_addr_in = 5'd7; write_back_mux_sel_in = 1'b1;
        @(negedge clk);
        n_tests++; if (stall_out !== 1'b0) begin n_fail++; $display("FAIL alu_stall: got %b want 0", stall_out); end
        @(posedge clk); #1;
        n_tests++; if (alu_data_out !== 32'h1234) begin n_fail++; $display("FAIL alu_data: got %h want 00001234", alu_data_out); end
        n_tests++; if ({reg_wr_en_out, reg_wr_addr_out, write_back_mux_sel_out} !== {1'b1, 5'd7, 1'b1}) begin
            n_fail++; $display("FAIL alu_ctrl: got en=%b addr=%0d sel=%b want 1/7/1", reg_wr_en_out, reg_wr_addr_out, write_back_mux_sel_out); end
        n_tests++; if (dmem_req_out !== 1'b0) begin n_fail++; $display("FAIL alu_noreq: got %b want 0", dmem_req_out); end
        ex_valid_in = 1'b0; alu_data_in = 32'h55;
        @(posedge clk); #1;
        n_tests++; if (reg_wr_en_out !== 1'b0) begin n_fail++; $display("FAIL invalid_wr_en: got %b want 0", reg_wr_en_out); end
        n_tests++; if (alu_data_out !== 32'h55) begin n_fail++; $display("FAIL invalid_alu: got %h want 00000055", alu_data_out); end
        idle_inputs();
    endtask

    task automatic test_load_word();
        int st, pu; logic rq, we, sb, wbo, ra; logic [31:0] ad, wd, md, ao; logic [3:0] be; logic [4:0] rwo;
        do_mem(32'h100, 2'b10, 1'b0, 1'b1, 1'b0, 32'h0, 1'b1, 5'd9, 1'b1, 3, 32'hDEADBEEF,
               st, pu, rq, we, ad, be, wd, sb, md, ao, rwo, wbo, ra);
        n_tests++; if (st !== 4) begin n_fail++; $display("FAIL lw_stall_cycles: got %0d want 4", st); end
        n_tests++; if ({rq, we} !== 2'b10) begin n_fail++; $display("FAIL lw_req_we: got %b want 10", {rq, we}); end
        n_tests++; if (ad !== 32'h100) begin n_fail++; $display("FAIL lw_addr: got %h want 00000100", ad); end
        n_tests++; if (be !== 4'b1111) begin n_fail++; $display("FAIL lw_be: got %b want 1111", be); end
        n_tests++; if (sb !== 1'b1) begin n_fail++; $display("FAIL lw_req_stable: got %b want 1", sb); end
        n_tests++; if (md !== 32'hDEADBEEF) begin n_fail++; $display("FAIL lw_data: got %h want deadbeef", md); end
        n_tests++; if (pu !== 1) begin n_fail++; $display("FAIL lw_wr_pulses: got %0d want 1", pu); end
        n_tests++; if ({ao, rwo, wbo} !== {32'h100, 5'd9, 1'b1}) begin n_fail++; $display("FAIL lw_passthru: got %h/%0d/%b want 00000100/9/1", ao, rwo, wbo); end
        n_tests++; if (ra !== 1'b0) begin n_fail++; $display("FAIL lw_req_drop: got %b want 0", ra); end
    endtask

    task automatic test_load_narrow();
        int st, pu; logic rq, we, sb, wbo, ra; logic [31:0] ad, wd, md, ao; logic [3:0] be; logic [4:0] rwo;
        do_mem(32'h103, 2'b00, 1'b1, 1'b1, 1'b0, 32'h0, 1'b1, 5'd3, 1'b1, 0, 32'h000000F0,
               st, pu, rq, we, ad, be, wd, sb, md, ao, rwo, wbo, ra);
        n_tests++; if (md !== 32'hFFFFFFF0) begin n_fail++; $display("FAIL lb_signed: got %h want fffffff0", md); end
        n_tests++; if ({ad, be} !== {32'h100, 4'b0001}) begin n_fail++; $display("FAIL lb_lane: got %h/%b want 00000100/0001", ad, be); end
        n_tests++; if (st !== 1) begin n_fail++; $display("FAIL lb_stall_min: got %0d want 1", st); end
        n_tests++; if (ao !== 32'h103) begin n_fail++; $display("FAIL lb_alu: got %h want 00000103", ao); end
        do_mem(32'h103, 2'b00, 1'b0, 1'b1, 1'b0, 32'h0, 1'b1, 5'd3, 1'b1, 1, 32'h000000F0,
               st, pu, rq, we, ad, be, wd, sb, md, ao, rwo, wbo, ra);
        n_tests++; if (md !== 32'h000000F0) begin n_fail++; $display("FAIL lbu_unsigned: got %h want 000000f0", md); end
        do_mem(32'h400, 2'b00, 1'b1, 1'b1, 1'b0, 32'h0, 1'b1, 5'd4, 1'b1, 0, 32'h7F00_00FF,
               st, pu, rq, we, ad, be, wd, sb, md, ao, rwo, wbo, ra);
        n_tests++; if ({md, be} !== {32'h0000007F, 4'b1000}) begin n_fail++; $display("FAIL lb_offset0: got %h/%b want 0000007f/1000", md, be); end
        do_mem(32'h102, 2'b01, 1'b1, 1'b1, 1'b0, 32'h0, 1'b1, 5'd5, 1'b1, 2, 32'h1234_8765,
               st, pu, rq, we, ad, be, wd, sb, md, ao, rwo, wbo, ra);
        n_tests++; if ({md, be} !== {32'hFFFF8765, 4'b0011}) begin n_fail++; $display("FAIL lh_signed: got %h/%b want ffff8765/0011", md, be); end
        do_mem(32'h100, 2'b01, 1'b0, 1'b1, 1'b0, 32'h0, 1'b1, 5'd5, 1'b1, 0, 32'h8765_1234,
               st, pu, rq, we, ad, be, wd, sb, md, ao, rwo, wbo, ra);
        n_tests++; if ({md, be} !== {32'h00008765, 4'b1100}) begin n_fail++; $display("FAIL lhu_upper: got %h/%b want 00008765/1100", md, be); end
        do_mem(32'h104, 2'b11, 1'b1, 1'b1, 1'b0, 32'h0, 1'b1, 5'd6, 1'b0, 0, 32'h8102_0304,
               st, pu, rq, we, ad, be, wd, sb, md, ao, rwo, wbo, ra);
        n_tests++; if ({md, be} !== {32'h81020304, 4'b1111}) begin n_fail++; $display("FAIL lw_size11: got %h/%b want 81020304/1111", md, be); end
    endtask

    task automatic test_back_to_back();
        int st, pu; logic rq, we, sb, wbo, ra; logic [31:0] ad, wd, md, ao; logic [3:0] be; logic [4:0] rwo;
        do_mem(32'h500, 2'b10, 1'b0, 1'b1, 1'b0, 32'h0, 1'b1, 5'd11, 1'b1, 1, 32'h1357_9BDF,
               st, pu, rq, we, ad, be, wd, sb, md, ao, rwo, wbo, ra);
        ex_valid_in = 1'b1; alu_data_in = 32'h77; reg_wr_en_in = 1'b1; reg_wr_addr_in = 5'd12; write_back_mux_sel_in = 1'b0;
        @(posedge clk); #1;
        n_tests++; if ({mem_data_out, alu_data_out} !== {32'h13579BDF, 32'h77}) begin
            n_fail++; $display("FAIL hold_mem_data: got %h/%h want 13579bdf/00000077", mem_data_out, alu_data_out); end
        n_tests++; if ({reg_wr_en_out, reg_wr_addr_out} !== {1'b1, 5'd12}) begin
            n_fail++; $display("FAIL b2b_alu_ctrl: got %b/%0d want 1/12", reg_wr_en_out, reg_wr_addr_out); end
        idle_inputs();
    endtask

    task automatic test_store();
        int st, pu; logic rq, we, sb, wbo, ra; logic [31:0] ad, wd, md, ao; logic [3:0] be; logic [4:0] rwo;
        do_mem(32'h202, 2'b01, 1'b0, 1'b0, 1'b1, 32'h0000ABCD, 1'b0, 5'd0, 1'b0, 1, 32'h0,
               st, pu, rq, we, ad, be, wd, sb, md, ao, rwo, wbo, ra);
        n_tests++; if ({rq, we, be} !== 6'b11_0011) begin n_fail++; $display("FAIL sh_req_we_be: got %b want 110011", {rq, we, be}); end
        n_tests++; if ({ad, wd} !== {32'h200, 32'hABCDABCD}) begin n_fail++; $display("FAIL sh_addr_wdata: got %h/%h want 00000200/abcdabcd", ad, wd); end
        n_tests++; if (pu !== 0) begin n_fail++; $display("FAIL sh_no_write: got %0d want 0", pu); end
        do_mem(32'h201, 2'b00, 1'b0, 1'b1, 1'b1, 32'h1234_565A, 1'b1, 5'd8, 1'b0, 0, 32'h0,
               st, pu, rq, we, ad, be, wd, sb, md, ao, rwo, wbo, ra);
        n_tests++; if ({we, be, wd} !== {1'b1, 4'b0100, 32'h5A5A5A5A}) begin n_fail++; $display("FAIL sb_both_en: got %b/%b/%h want 1/0100/5a5a5a5a", we, be, wd); end
        n_tests++; if (pu !== 0) begin n_fail++; $display("FAIL sb_both_no_write: got %0d want 0", pu); end
        do_mem(32'h20C, 2'b10, 1'b0, 1'b0, 1'b1, 32'hCAFEF00D, 1'b0, 5'd0, 1'b0, 2, 32'h0,
               st, pu, rq, we, ad, be, wd, sb, md, ao, rwo, wbo, ra);
        n_tests++; if ({ad, be, wd, sb} !== {32'h20C, 4'b1111, 32'hCAFEF00D, 1'b1}) begin
            n_fail++; $display("FAIL sw: got %h/%b/%h/%b want 0000020c/1111/cafef00d/1", ad, be, wd, sb); end
    endtask

    task automatic test_reset_in_access();
        ex_valid_in = 1'b1; alu_data_in = 32'h300; mem_size_in = 2'b10; mem_rd_en_in = 1'b1;
        reg_wr_en_in = 1'b1; reg_wr_addr_in = 5'd2;
        @(posedge clk); #1;
        n_tests++; if (dmem_req_out !== 1'b1) begin n_fail++; $display("FAIL rsta_req_up: got %b want 1", dmem_req_out); end
        idle_inputs();
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0; dmem_ack_in = 1'b1; dmem_rdata_in = 32'hFFFF_FFFF;
        n_tests++; if ({dmem_req_out, reg_wr_en_out} !== 2'b00) begin n_fail++; $display("FAIL rsta_drop: got req=%b wr=%b want 0/0", dmem_req_out, reg_wr_en_out); end
        @(posedge clk); #1;
        dmem_ack_in = 1'b0;
        n_tests++; if ({dmem_req_out, reg_wr_en_out, mem_data_out} !== 34'h0) begin
            n_fail++; $display("FAIL rsta_late_ack: got req=%b wr=%b data=%h want 0/0/0", dmem_req_out, reg_wr_en_out, mem_data_out); end
        @(negedge clk);
        n_tests++; if (stall_out !== 1'b0) begin n_fail++; $display("FAIL rsta_idle: got stall=%b want 0", stall_out); end
        @(posedge clk); #1;
    endtask

`ifdef MEM_MISALIGN_TRAP_EN
    task automatic test_misalign();
        ex_valid_in = 1'b1; alu_data_in = 32'h101; mem_size_in = 2'b10; mem_rd_en_in = 1'b1;
        reg_wr_en_in = 1'b1; reg_wr_addr_in = 5'd3;
        @(negedge clk);
        n_tests++; if (stall_out !== 1'b0) begin n_fail++; $display("FAIL trap_stall: got %b want 0", stall_out); end
        @(posedge clk); #1;
        n_tests++; if ({misalign_exc_out, dmem_req_out, reg_wr_en_out} !== 3'b100) begin
            n_fail++; $display("FAIL trap_lw: got exc=%b req=%b wr=%b want 1/0/0", misalign_exc_out, dmem_req_out, reg_wr_en_out); end
        idle_inputs();
        @(posedge clk); #1;
        n_tests++; if ({misalign_exc_out, dmem_req_out} !== 2'b00) begin n_fail++; $display("FAIL trap_pulse: got exc=%b req=%b want 0/0", misalign_exc_out, dmem_req_out); end
        ex_valid_in = 1'b1; alu_data_in = 32'h103; mem_size_in = 2'b01; mem_wr_en_in = 1'b1;
        @(posedge clk); #1;
        n_tests++; if ({misalign_exc_out, dmem_req_out} !== 2'b10) begin n_fail++; $display("FAIL trap_sh: got exc=%b req=%b want 1/0", misalign_exc_out, dmem_req_out); end
        idle_inputs();
        @(posedge clk); #1;
    endtask
`else
    task automatic test_misalign();
        int st, pu; logic rq, we, sb, wbo, ra; logic [31:0] ad, wd, md, ao; logic [3:0] be; logic [4:0] rwo;
        do_mem(32'h101, 2'b10, 1'b0, 1'b1, 1'b0, 32'h0, 1'b1, 5'd3, 1'b0, 0, 32'hA1B2C3D4,
               st, pu, rq, we, ad, be, wd, sb, md, ao, rwo, wbo, ra);
        n_tests++; if ({rq, ad, be, md} !== {1'b1, 32'h100, 4'b1111, 32'hA1B2C3D4}) begin
            n_fail++; $display("FAIL mis_lw: got %b/%h/%b/%h want 1/00000100/1111/a1b2c3d4", rq, ad, be, md); end
        do_mem(32'h103, 2'b01, 1'b0, 1'b1, 1'b0, 32'h0, 1'b1, 5'd3, 1'b0, 0, 32'h1111_2222,
               st, pu, rq, we, ad, be, wd, sb, md, ao, rwo, wbo, ra);
        n_tests++; if ({be, md} !== {4'b0011, 32'h00002222}) begin n_fail++; $display("FAIL mis_lh: got %b/%h want 0011/00002222", be, md); end
    endtask
`endif

    initial begin
        test_reset();
        test_alu_op();
        test_load_word();
        test_load_narrow();
        test_back_to_back();
        test_store();
        test_reset_in_access();
        test_misalign();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
